// File: rtl/dma_sched_pkg.sv
// Shared types and constants for the DMA burst scheduler.
package dma_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  localparam int unsigned DEF_BURST_LEN  = 16;
  localparam int unsigned DEF_CAP_BURSTS = 64;
  localparam int unsigned DW             = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dma_rr_arb.sv
// Combinational round-robin picker: first eligible channel at or after ptr_i, wrapping.
module dma_rr_arb
  import dma_sched_pkg::*;
#(
  parameter int unsigned NCH = 2,
  localparam int unsigned IW = (NCH > 1) ? clog2(NCH) : 1
) (
  input  logic [NCH-1:0] elig_i,
  input  logic [IW-1:0]  ptr_i,
  output logic [IW-1:0]  grant_c_o,
  output logic           any_c_o
);

  always_comb begin
    int unsigned idx;
    logic [IW-1:0] idx_w;
    grant_c_o = '0;
    any_c_o   = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= NCH) idx = idx - NCH;
      idx_w = IW'(idx);
      if (!any_c_o && elig_i[idx_w]) begin
        any_c_o   = 1'b1;
        grant_c_o = idx_w;
      end
    end
  end

endmodule

// File: rtl/dma_burst_sched.sv
// Credit-based round-robin scheduler of SDRAM read bursts into NCH DMA FIFO channels.
module dma_burst_sched
  import dma_sched_pkg::*;
#(
  parameter int unsigned NCH        = 2,
  parameter int unsigned CAP_BURSTS = DEF_CAP_BURSTS,
  parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
  parameter int unsigned CW         = 7,
  localparam int unsigned CHW = (NCH > 1) ? clog2(NCH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NCH-1:0]  en_i,
  input  logic [NCH-1:0]  src_pend_i,
  input  logic [NCH-1:0]  rd_burst_i,
  output logic            req_o,
  output logic [CHW-1:0]  req_ch_o,
  input  logic            req_ack_i,
  input  logic            src_dv_i,
  input  logic [DW-1:0]   src_d_i,
  output logic [NCH-1:0]  we_o,
  output logic [DW-1:0]   di_o,
  output logic            busy_o,
  output logic [NCH-1:0]  ovf_o
);

  localparam int unsigned     WCW  = clog2(BURST_LEN);
  localparam logic [CW-1:0]   CAP  = CW'(CAP_BURSTS);
  localparam logic [WCW-1:0]  LAST = WCW'(BURST_LEN - 1);

  state_e         state_q, state_d;
  logic [CHW-1:0] ptr_q, ptr_d, req_ch_q, req_ch_d, grant;
  logic [WCW-1:0] cnt_q, cnt_d;
  logic           req_q, req_d, busy_q, busy_d, any_elig;
  logic [NCH-1:0] we_q, we_d, ovf_q, ovf_d, elig, take;
  logic [DW-1:0]  di_q, di_d;
  logic [CW-1:0]  credit_q [NCH];
  logic [CW-1:0]  credit_d [NCH];

  always_comb begin
    elig = '0;
    take = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      elig[c] = en_i[c] & src_pend_i[c] & (credit_q[c] != '0);
      take[c] = (state_q == ST_REQ) & req_ack_i & (req_ch_q == CHW'(c));
    end
  end

  dma_rr_arb #(.NCH(NCH)) u_arb (
    .elig_i    (elig),
    .ptr_i     (ptr_q),
    .grant_c_o (grant),
    .any_c_o   (any_elig)
  );

  // Credits: disable wins, simultaneous take and release cancel, release at full saturates.
  always_comb begin
    ovf_d = ovf_q;
    for (int unsigned c = 0; c < NCH; c++) begin
      credit_d[c] = credit_q[c];
      if (!en_i[c]) begin
        credit_d[c] = CAP;
        ovf_d[c]    = 1'b0;
      end else if (rd_burst_i[c] && !take[c]) begin
        if (credit_q[c] == CAP) ovf_d[c] = 1'b1;
        else                    credit_d[c] = credit_q[c] + CW'(1);
      end else if (take[c] && !rd_burst_i[c]) begin
        credit_d[c] = credit_q[c] - CW'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    req_ch_d = req_ch_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    we_d     = '0;
    di_d     = di_q;
    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          req_ch_d = grant;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        // An accepted request must be followed through to keep word alignment.
        if (req_ack_i) begin
          ptr_d   = (req_ch_q == CHW'(NCH - 1)) ? '0 : req_ch_q + CHW'(1);
          cnt_d   = '0;
          state_d = ST_XFER;
        end else if (!en_i[req_ch_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (src_dv_i) begin
          cnt_d = cnt_q + WCW'(1);
          if (en_i[req_ch_q]) begin
            we_d[req_ch_q] = 1'b1;
            di_d           = src_d_i;
          end
          if (cnt_q == LAST) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_d  = (state_d == ST_REQ);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      req_ch_q <= '0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      we_q     <= '0;
      di_q     <= '0;
      ovf_q    <= '0;
      for (int unsigned c = 0; c < NCH; c++) credit_q[c] <= CAP;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      req_ch_q <= req_ch_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      we_q     <= we_d;
      di_q     <= di_d;
      ovf_q    <= ovf_d;
      for (int unsigned c = 0; c < NCH; c++) credit_q[c] <= credit_d[c];
    end
  end

  assign req_o    = req_q;
  assign req_ch_o = req_ch_q;
  assign we_o     = we_q;
  assign di_o     = di_q;
  assign busy_o   = busy_q;
  assign ovf_o    = ovf_q;

endmodule
